// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU job sequencer and its neighbours.
// The quiet-NaN helper returns a full 64-bit pattern; callers keep the low PRECISION bits.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

    function automatic logic [63:0] qnan(input int unsigned precision);
        if (precision == 64) begin
            return 64'h7FF8_0000_0000_0000;
        end
        return 64'h0000_0000_7FC0_0000;
    endfunction

endpackage

// File: rtl/fpu_job_sequencer.sv
// Initiator for one FPU: accepts a job, pulses FpuReset, waits for Done (or times out)
// and returns result, tag and timeout status over a valid/ready response channel.
module fpu_job_sequencer
    import fpu_pkg::*;
#(
    parameter int PRECISION      = 32,
    parameter int TAG_W          = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic [1:0]           CmdOp,
    input  logic [PRECISION-1:0] CmdA,
    input  logic [PRECISION-1:0] CmdB,
    input  logic [TAG_W-1:0]     CmdTag,
    output logic [PRECISION-1:0] FpuA,
    output logic [PRECISION-1:0] FpuB,
    output logic [1:0]           FpuOp,
    output logic                 FpuReset,
    input  logic [PRECISION-1:0] FpuResult,
    input  logic                 FpuDone,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [PRECISION-1:0] RspResult,
    output logic [TAG_W-1:0]     RspTag,
    output logic                 RspTimeout
);

    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int START_W = $clog2(START_CYCLES + 1);

    localparam logic [WAIT_W-1:0]    WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0]    WAIT_MAX   = '1;
    localparam logic [START_W-1:0]   START_LAST = START_W'(START_CYCLES - 1);
    localparam logic [63:0]          QNAN_FULL  = qnan(PRECISION);
    localparam logic [PRECISION-1:0] QNAN       = QNAN_FULL[PRECISION-1:0];

    seq_state_e           state_q,       state_d;
    logic [PRECISION-1:0] fpu_a_q,       fpu_a_d;
    logic [PRECISION-1:0] fpu_b_q,       fpu_b_d;
    fpu_op_e              fpu_op_q,      fpu_op_d;
    logic                 fpu_reset_q,   fpu_reset_d;
    logic                 rsp_valid_q,   rsp_valid_d;
    logic [PRECISION-1:0] rsp_result_q,  rsp_result_d;
    logic [TAG_W-1:0]     rsp_tag_q,     rsp_tag_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic [START_W-1:0]   start_cnt_q,   start_cnt_d;
    logic [WAIT_W-1:0]    wait_cnt_q,    wait_cnt_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            fpu_op_q      <= OP_ADD;
            fpu_reset_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_tag_q     <= '0;
            rsp_timeout_q <= 1'b0;
            start_cnt_q   <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fpu_a_q       <= fpu_a_d;
            fpu_b_q       <= fpu_b_d;
            fpu_op_q      <= fpu_op_d;
            fpu_reset_q   <= fpu_reset_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_timeout_q <= rsp_timeout_d;
            start_cnt_q   <= start_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fpu_a_d       = fpu_a_q;
        fpu_b_d       = fpu_b_q;
        fpu_op_d      = fpu_op_q;
        fpu_reset_d   = fpu_reset_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_timeout_d = rsp_timeout_q;
        start_cnt_d   = start_cnt_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (CmdValid) begin
                    fpu_a_d     = CmdA;
                    fpu_b_d     = CmdB;
                    fpu_op_d    = fpu_op_e'(CmdOp);
                    rsp_tag_d   = CmdTag;
                    fpu_reset_d = 1'b1;
                    start_cnt_d = '0;
                    state_d     = ST_START;
                end
            end
            // Done is not looked at here: it may still be high from the previous job.
            ST_START: begin
                if (start_cnt_q == START_LAST) begin
                    fpu_reset_d = 1'b0;
                    wait_cnt_d  = '0;
                    state_d     = ST_WAIT;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            // Done is tested before the timeout so a coincident Done still delivers a result.
            ST_WAIT: begin
                if (FpuDone) begin
                    rsp_result_d  = FpuResult;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_result_d  = QNAN;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (RspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign CmdReady   = (state_q == ST_IDLE);
    assign FpuA       = fpu_a_q;
    assign FpuB       = fpu_b_q;
    assign FpuOp      = fpu_op_q;
    assign FpuReset   = fpu_reset_q;
    assign RspValid   = rsp_valid_q;
    assign RspResult  = rsp_result_q;
    assign RspTag     = rsp_tag_q;
    assign RspTimeout = rsp_timeout_q;

endmodule

// File: doc/fpu_job_sequencer.md
Name: fpu_job_sequencer

Overview:
Initiator side of the FPU operation protocol. It accepts operation jobs over a valid/ready command interface and drives the FPU's operand, Operation and start (FPU Reset) inputs. It waits for Done, then returns the result, tag and timeout status over a valid/ready response interface. It sits between a job source (CPU-side register block or test sequencer) and one FPU instance, and it replaces bench-side timed start pulses.

Parameters:
PRECISION, 32, operand/result width in bits (32 or 64)
TAG_W, 4, width of the job tag echoed with the response
START_CYCLES, 2, number of cycles FpuReset is held high per job (min 1)
TIMEOUT_CYCLES, 64, maximum WAIT cycles before the job is aborted

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
CmdValid  in  1  job offered
CmdReady  out  1  sequencer can accept a job
CmdOp  in  2  00 add, 01 sub, 10 mul, 11 div
CmdA  in  PRECISION  operand A bits
CmdB  in  PRECISION  operand B bits
CmdTag  in  TAG_W  job identifier
FpuA  out  PRECISION  operand A to FPU
FpuB  out  PRECISION  operand B to FPU
FpuOp  out  2  Operation to FPU
FpuReset  out  1  FPU start/clear, active-high
FpuResult  in  PRECISION  FPU Result
FpuDone  in  1  FPU Done
RspValid  out  1  response available
RspReady  in  1  consumer accepts response
RspResult  out  PRECISION  result bits (quiet NaN on timeout)
RspTag  out  TAG_W  echoed CmdTag
RspTimeout  out  1  job aborted by timeout

Behaviour:
- Async reset (Reset=0) puts the FSM in IDLE and clears FpuA, FpuB, FpuOp, FpuReset, RspValid, RspResult, RspTag, RspTimeout and both counters to 0. CmdReady=1 during and after reset.
- All outputs are registered except CmdReady, which is decoded from state==IDLE.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: on CmdValid&CmdReady, latch CmdA/B/Op/Tag into FpuA/B/Op and the tag register, set FpuReset=1, clear the counter, and go to START.
- START: FpuReset=1 for exactly START_CYCLES cycles. FpuDone is ignored because it may be stale from the previous job. At the end, FpuReset=0 and the FSM goes to WAIT.
- WAIT: the wait counter increments each cycle.
  - FpuDone=1 sampled: RspResult<=FpuResult, RspTimeout<=0, RspValid<=1, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no Done: RspResult<=QNAN, RspTimeout<=1, RspValid<=1, go to RESP.
  - Done on the same cycle as the timeout: Done wins.
- RESP: RspValid, RspResult, RspTag and RspTimeout are held stable until RspReady=1. On the handshake cycle, RspValid<=0 and the FSM returns to IDLE, so a new job is accepted one cycle later at the earliest.
- FpuA/B/Op hold their values from acceptance until the next accepted job; they are never changed mid-operation.
- Latency: with job accepted at edge T and FPU latency L cycles after FpuReset falls, RspValid rises at edge T+START_CYCLES+L+1.
- Counter width: clog2(TIMEOUT_CYCLES+1). The counter saturates and does not wrap.
- Reset asserted mid-START or mid-WAIT: immediate return to IDLE with reset values. A later FpuDone is ignored while in IDLE.
- CmdValid while not IDLE: no effect, because CmdReady=0.
- RspReady while RspValid=0: no effect.

Decomposition:
- Shared package fpu_pkg:
  - fpu_op_e enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - Function qnan(PRECISION): 32'h7FC00000 for 32 bits, 64'h7FF8000000000000 for 64 bits.
  - seq_state_e enum for the FSM states.
- No sub-module; a single FSM with one counter is the natural structure.

Test Plan:
1. Add 0x3FC00000+0x3FC00000, tag 5, model latency 40 -> FpuReset high exactly 2 cycles, FpuOp=00; RspResult=0x40400000, RspTag=5, RspTimeout=0 at T+43.
2. Div 0x41000000/0x40000000, op 11 -> FpuOp=11 throughout; RspResult=0x40800000, RspTimeout=0.
3. RspReady held low 10 cycles after RspValid -> RspValid/RspResult/RspTag stable, CmdReady=0 throughout; second queued job accepted the cycle after the handshake.
4. Model never asserts FpuDone, TIMEOUT_CYCLES=64 -> RspValid after 64 WAIT cycles with RspResult=0x7FC00000, RspTimeout=1.
5. Model holds FpuDone=1 during START (stale) then drops it, real Done after 30 -> stale Done ignored; a single response at the real Done.
6. Reset driven low in WAIT cycle 10, released, then FpuDone pulses -> all outputs return to 0, CmdReady=1, no response issued; the next job completes normally.
